// File: rtl/ddr3_bist_pkg.sv
// Shared state type, AXI constants and test pattern for the DDR3 AXI BIST.
package ddr3_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    FIN
  } bist_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Word written to, and expected back from, a given byte address.
  function automatic logic [31:0] bist_pattern(input logic [31:0] i_addr,
                                               input logic [31:0] i_seed);
    return i_addr ^ i_seed;
  endfunction

endpackage

// File: rtl/ddr3_bist_chk.sv
// Response and read-data checker: flags bad write responses and bad read beats,
// keeps a saturating error count and the byte address of the first error.
module ddr3_bist_chk
  import ddr3_bist_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_bCheck,
  input  logic [3:0]  i_bid,
  input  logic [1:0]  i_bresp,
  input  logic [31:0] i_bAddr,
  input  logic        i_rCheck,
  input  logic [3:0]  i_rid,
  input  logic [1:0]  i_rresp,
  input  logic [31:0] i_rdata,
  input  logic        i_rlast,
  input  logic        i_lastBeat,
  input  logic [31:0] i_rAddr,
  input  logic [31:0] i_seed,
  output logic [15:0] o_errCount,
  output logic [31:0] o_firstErrAddr
);

  logic        w_bErr;
  logic        w_rErr;
  logic        w_err;
  logic [31:0] w_errAddr;
  logic [15:0] r_errCount;
  logic [31:0] r_firstErrAddr;

  // Classify this cycle's write response or read beat; several faults in one beat collapse to one error.
  always_comb begin
    w_bErr    = i_bCheck && ((i_bresp != AXI_RESP_OKAY) || (i_bid != AXI_ID));
    w_rErr    = i_rCheck && ((i_rdata != bist_pattern(i_rAddr, i_seed)) ||
                             (i_rresp != AXI_RESP_OKAY) ||
                             (i_rid != AXI_ID) ||
                             (i_rlast != i_lastBeat));
    w_err     = w_bErr || w_rErr;
    w_errAddr = w_bErr ? i_bAddr : i_rAddr;
  end

  // Saturating error counter; the first-error address is captured only on the 0->1 step.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_errCount     <= '0;
      r_firstErrAddr <= '0;
    end else if (w_err) begin
      if (r_errCount != 16'hFFFF) r_errCount <= r_errCount + 16'd1;
      if (r_errCount == 16'd0) r_firstErrAddr <= w_errAddr;
    end
  end

  assign o_errCount     = r_errCount;
  assign o_firstErrAddr = r_firstErrAddr;

endmodule

// File: rtl/ddr3_axi_bist.sv
// AXI4 memory BIST: writes addr^seed over a region in fixed bursts, reads it back and checks it.
module ddr3_axi_bist
  import ddr3_bist_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 4096,
  parameter int unsigned BURST_LEN = 16,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic [3:0]  axi4_awid,
  output logic [31:0] axi4_awaddr,
  output logic [7:0]  axi4_awlen,
  output logic [1:0]  axi4_awburst,
  output logic        axi4_awvalid,
  input  logic        axi4_awready,
  output logic [31:0] axi4_wdata,
  output logic [3:0]  axi4_wstrb,
  output logic        axi4_wlast,
  output logic        axi4_wvalid,
  input  logic        axi4_wready,
  input  logic [3:0]  axi4_bid,
  input  logic [1:0]  axi4_bresp,
  input  logic        axi4_bvalid,
  output logic        axi4_bready,
  output logic [3:0]  axi4_arid,
  output logic [31:0] axi4_araddr,
  output logic [7:0]  axi4_arlen,
  output logic [1:0]  axi4_arburst,
  output logic        axi4_arvalid,
  input  logic        axi4_arready,
  input  logic [3:0]  axi4_rid,
  input  logic [31:0] axi4_rdata,
  input  logic [1:0]  axi4_rresp,
  input  logic        axi4_rlast,
  input  logic        axi4_rvalid,
  output logic        axi4_rready
);

  localparam logic [7:0]  LEN_M1      = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] LAST_BURST  = 32'(WORDS / BURST_LEN - 1);

  bist_state_e r_state;
  bist_state_e w_nextState;
  logic [31:0] r_seed;
  logic [31:0] r_addr;
  logic [7:0]  r_beat;
  logic [31:0] r_burst;
  logic        w_start;
  logic        w_lastBeat;
  logic        w_lastBurst;
  logic        w_wHs;
  logic        w_bHs;
  logic        w_rHs;
  logic [31:0] w_beatAddr;

  assign w_start     = start && ((r_state == IDLE) || (r_state == FIN));
  assign w_lastBeat  = (r_beat == LEN_M1);
  assign w_lastBurst = (r_burst == LAST_BURST);
  assign w_wHs       = axi4_wvalid && axi4_wready;
  assign w_bHs       = axi4_bvalid && axi4_bready;
  assign w_rHs       = axi4_rvalid && axi4_rready;
  assign w_beatAddr  = r_addr + {22'd0, r_beat, 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic: write all bursts, then read them all back, one burst outstanding at a time.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE, FIN: if (start)                      w_nextState = WR_ADDR;
      WR_ADDR:   if (axi4_awready)               w_nextState = WR_DATA;
      WR_DATA:   if (w_wHs && w_lastBeat)        w_nextState = WR_RESP;
      WR_RESP:   if (axi4_bvalid)                w_nextState = w_lastBurst ? RD_ADDR : WR_ADDR;
      RD_ADDR:   if (axi4_arready)               w_nextState = RD_DATA;
      RD_DATA:   if (w_rHs && w_lastBeat)        w_nextState = w_lastBurst ? FIN : RD_ADDR;
      default:                                   w_nextState = IDLE;
    endcase
  end

  // Output decode: handshakes, burst attributes and status all follow directly from the state.
  always_comb begin
    axi4_awvalid = (r_state == WR_ADDR);
    axi4_wvalid  = (r_state == WR_DATA);
    axi4_bready  = (r_state == WR_RESP);
    axi4_arvalid = (r_state == RD_ADDR);
    axi4_rready  = (r_state == RD_DATA);
    busy         = (r_state != IDLE) && (r_state != FIN);
    done         = (r_state == FIN);
    pass         = (r_state == FIN) && (err_count == 16'd0);
    axi4_awid    = AXI_ID;
    axi4_arid    = AXI_ID;
    axi4_awaddr  = r_addr;
    axi4_araddr  = r_addr;
    axi4_awlen   = LEN_M1;
    axi4_arlen   = LEN_M1;
    axi4_awburst = AXI_BURST_INCR;
    axi4_arburst = AXI_BURST_INCR;
    axi4_wdata   = bist_pattern(w_beatAddr, r_seed);
    axi4_wstrb   = 4'hF;
    axi4_wlast   = w_lastBeat;
  end

  // Seed latch plus burst address, beat and burst counters; the address only moves between bursts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seed  <= '0;
      r_addr  <= BASE_ADDR;
      r_beat  <= '0;
      r_burst <= '0;
    end else if (w_start) begin
      r_seed  <= seed;
      r_addr  <= BASE_ADDR;
      r_beat  <= '0;
      r_burst <= '0;
    end else begin
      if (w_wHs || w_rHs) r_beat <= w_lastBeat ? 8'd0 : r_beat + 8'd1;
      if (w_bHs || (w_rHs && w_lastBeat)) begin
        if (w_lastBurst) begin
          r_addr  <= BASE_ADDR;
          r_burst <= '0;
        end else begin
          r_addr  <= r_addr + BURST_BYTES;
          r_burst <= r_burst + 32'd1;
        end
      end
    end
  end

  ddr3_bist_chk #(
    .AXI_ID(AXI_ID)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_start),
    .i_bCheck      (w_bHs),
    .i_bid         (axi4_bid),
    .i_bresp       (axi4_bresp),
    .i_bAddr       (r_addr),
    .i_rCheck      (w_rHs),
    .i_rid         (axi4_rid),
    .i_rresp       (axi4_rresp),
    .i_rdata       (axi4_rdata),
    .i_rlast       (axi4_rlast),
    .i_lastBeat    (w_lastBeat),
    .i_rAddr       (w_beatAddr),
    .i_seed        (r_seed),
    .o_errCount    (err_count),
    .o_firstErrAddr(first_err_addr)
  );

endmodule

// File: tb/tb_ddr3_axi_bist.sv
// Bench for ddr3_axi_bist: memory-backed AXI slave with optional stalls and faults,
// plus a region-level model of the expected burst and data sequence.
module tb_ddr3_axi_bist;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int WORDS_P = 32;
  localparam int BL      = 16;
  localparam int NBURST  = WORDS_P / BL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic [3:0]  axi4_awid, axi4_arid, axi4_bid, axi4_rid;
  logic [31:0] axi4_awaddr, axi4_araddr, axi4_wdata, axi4_rdata;
  logic [7:0]  axi4_awlen, axi4_arlen;
  logic [1:0]  axi4_awburst, axi4_arburst, axi4_bresp, axi4_rresp;
  logic [3:0]  axi4_wstrb;
  logic        axi4_awvalid, axi4_awready, axi4_wlast, axi4_wvalid, axi4_wready;
  logic        axi4_bvalid, axi4_bready, axi4_arvalid, axi4_arready;
  logic        axi4_rlast, axi4_rvalid, axi4_rready;

  int errors = 0;
  int checks = 0;

  bit          stallEn, flipEn, bErrEn;
  logic [31:0] seedModel;
  int          nAw, nW, nB, nAr, nR;
  logic [31:0] mem [0:63];
  logic [31:0] sWrAddr, sRdAddr;
  int          sWrBeat, sRdBeat, sBCount;
  bit          sBPend, sRdActive;
  bit          awPend, arPend;
  logic [31:0] awPendAddr, arPendAddr;
  logic [31:0] capAw1, capW17, capW31;

  ddr3_axi_bist #(
    .BASE_ADDR(BASE),
    .WORDS    (WORDS_P),
    .BURST_LEN(BL),
    .AXI_ID   (4'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .axi4_awid(axi4_awid), .axi4_awaddr(axi4_awaddr), .axi4_awlen(axi4_awlen),
    .axi4_awburst(axi4_awburst), .axi4_awvalid(axi4_awvalid), .axi4_awready(axi4_awready),
    .axi4_wdata(axi4_wdata), .axi4_wstrb(axi4_wstrb), .axi4_wlast(axi4_wlast),
    .axi4_wvalid(axi4_wvalid), .axi4_wready(axi4_wready),
    .axi4_bid(axi4_bid), .axi4_bresp(axi4_bresp), .axi4_bvalid(axi4_bvalid), .axi4_bready(axi4_bready),
    .axi4_arid(axi4_arid), .axi4_araddr(axi4_araddr), .axi4_arlen(axi4_arlen),
    .axi4_arburst(axi4_arburst), .axi4_arvalid(axi4_arvalid), .axi4_arready(axi4_arready),
    .axi4_rid(axi4_rid), .axi4_rdata(axi4_rdata), .axi4_rresp(axi4_rresp),
    .axi4_rlast(axi4_rlast), .axi4_rvalid(axi4_rvalid), .axi4_rready(axi4_rready)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave drives for the coming rising edge, from the slave's own burst state.
  task automatic slaveDrive();
    int ridx;
    if (!rst_n) begin
      axi4_awready = 1'b0; axi4_wready = 1'b0; axi4_arready = 1'b0;
      axi4_bvalid  = 1'b0; axi4_bid = 4'h0; axi4_bresp = 2'b00;
      axi4_rvalid  = 1'b0; axi4_rid = 4'h0; axi4_rresp = 2'b00;
      axi4_rdata   = 32'h0; axi4_rlast = 1'b0;
      sBPend = 0; sRdActive = 0; sWrBeat = 0; sRdBeat = 0; awPend = 0; arPend = 0;
    end else begin
      axi4_awready = stallEn ? 1'($urandom_range(0, 1)) : 1'b1;
      axi4_wready  = stallEn ? 1'($urandom_range(0, 1)) : 1'b1;
      axi4_arready = stallEn ? 1'($urandom_range(0, 1)) : 1'b1;
      axi4_bvalid  = sBPend;
      axi4_bid     = 4'h0;
      axi4_bresp   = (bErrEn && sBCount == 0) ? 2'b10 : 2'b00;
      axi4_rvalid  = sRdActive && (stallEn ? ($urandom_range(0, 1) == 1) : 1'b1);
      ridx         = int'((sRdAddr - BASE) >> 2) + sRdBeat;
      axi4_rdata   = mem[ridx % 64] ^
                     ((flipEn && (sRdAddr + 32'(sRdBeat * 4)) == 32'h44) ? 32'h1 : 32'h0);
      axi4_rlast   = (sRdBeat == BL - 1);
      axi4_rid     = 4'h0;
      axi4_rresp   = 2'b00;
    end
  endtask

  // Per-cycle compare: handshakes that will complete on the next edge are checked against the model.
  task automatic checkOutput();
    int widx;
    if (rst_n) begin
      if (!busy)
        check32("idleQuiet", {27'd0, axi4_awvalid, axi4_wvalid, axi4_bready, axi4_arvalid, axi4_rready}, 32'd0);
      check32("doneBusyExcl", {31'd0, done & busy}, 32'd0);
      check32("passNeedsDone", {31'd0, pass & ~done}, 32'd0);
      if (awPend) begin
        check32("awValidHeld", {31'd0, axi4_awvalid}, 32'd1);
        check32("awAddrStable", axi4_awaddr, awPendAddr);
      end
      if (arPend) begin
        check32("arValidHeld", {31'd0, axi4_arvalid}, 32'd1);
        check32("arAddrStable", axi4_araddr, arPendAddr);
      end
      awPend = axi4_awvalid && !axi4_awready; awPendAddr = axi4_awaddr;
      arPend = axi4_arvalid && !axi4_arready; arPendAddr = axi4_araddr;

      if (axi4_awvalid && axi4_awready) begin
        check32("awAddr", axi4_awaddr, BASE + 32'(nAw * BL * 4));
        check32("awLenBurstId", {20'd0, axi4_awlen, axi4_awburst, 2'b00}, {20'd0, 8'(BL - 1), 2'b01, 2'b00});
        check32("awId", {28'd0, axi4_awid}, 32'd0);
        if (nAw == 1) capAw1 = axi4_awaddr;
        sWrAddr = axi4_awaddr; sWrBeat = 0; nAw++;
      end
      if (axi4_wvalid && axi4_wready) begin
        check32("wData", axi4_wdata, (BASE + 32'(nW * 4)) ^ seedModel);
        check32("wLast", {31'd0, axi4_wlast}, {31'd0, (nW % BL) == BL - 1});
        check32("wStrb", {28'd0, axi4_wstrb}, 32'hF);
        if (nW == 17) capW17 = axi4_wdata;
        if (nW == 31) capW31 = axi4_wdata;
        widx = int'((sWrAddr - BASE) >> 2) + sWrBeat;
        mem[widx % 64] = axi4_wdata;
        sWrBeat++;
        if (axi4_wlast) sBPend = 1;
        nW++;
      end
      if (axi4_bvalid && axi4_bready) begin
        sBPend = 0; sBCount++; nB++;
      end
      if (axi4_arvalid && axi4_arready) begin
        check32("arAddr", axi4_araddr, BASE + 32'(nAr * BL * 4));
        check32("arLenBurstId", {20'd0, axi4_arlen, axi4_arburst, 2'b00}, {20'd0, 8'(BL - 1), 2'b01, 2'b00});
        check32("arId", {28'd0, axi4_arid}, 32'd0);
        sRdAddr = axi4_araddr; sRdBeat = 0; sRdActive = 1; nAr++;
      end
      if (axi4_rvalid && axi4_rready) begin
        sRdBeat++;
        if (sRdBeat == BL) sRdActive = 0;
        nR++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] s, input bit st, input bit fl, input bit be);
    stallEn = st; flipEn = fl; bErrEn = be; seedModel = s;
    nAw = 0; nW = 0; nB = 0; nAr = 0; nR = 0; sBCount = 0;
    @(posedge clk); #1;
    start = 1'b1; seed = s;
    @(posedge clk); #1;
    start = 1'b0; seed = 32'h0;
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while (!done && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL doneTimeout: got done=%0b required done=1 within %0d cycles", done, maxCycles);
    end
    @(negedge clk);
  endtask

  task automatic waitBeats(input int beats);
    int n = 0;
    while (nW < beats && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check32("beatWait", 32'(nW >= beats), 32'd1);
  endtask

  task automatic checkTraffic(input string tag);
    check32({tag, "_awCount"}, 32'(nAw), 32'(NBURST));
    check32({tag, "_wCount"},  32'(nW),  32'(WORDS_P));
    check32({tag, "_bCount"},  32'(nB),  32'(NBURST));
    check32({tag, "_arCount"}, 32'(nAr), 32'(NBURST));
    check32({tag, "_rCount"},  32'(nR),  32'(WORDS_P));
  endtask

  task automatic checkClean(input string tag);
    check32({tag, "_done"},     {31'd0, done}, 32'd1);
    check32({tag, "_pass"},     {31'd0, pass}, 32'd1);
    check32({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check32({tag, "_errCount"}, {16'd0, err_count}, 32'd0);
  endtask

  // Stimulus sequence, with the slave/compare loop running alongside in the same process.
  initial begin
    rst_n = 1'b0; start = 1'b0; seed = 32'h0;
    stallEn = 0; flipEn = 0; bErrEn = 0; seedModel = 32'h0;
    nAw = 0; nW = 0; nB = 0; nAr = 0; nR = 0;
    sBCount = 0; sBPend = 0; sRdActive = 0; sWrBeat = 0; sRdBeat = 0;
    sWrAddr = 32'h0; sRdAddr = 32'h0; awPend = 0; arPend = 0;
    awPendAddr = 32'h0; arPendAddr = 32'h0;
    capAw1 = 32'h0; capW17 = 32'h0; capW31 = 32'h0;
    fork
      forever begin
        @(negedge clk);
        slaveDrive();
        checkOutput();
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rstOutputs", {27'd0, busy, done, pass, axi4_awvalid, axi4_arvalid}, 32'd0);
        check32("rstErrCount", {16'd0, err_count}, 32'd0);
        check32("rstFirstErr", first_err_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] clean run, ideal slave");
        applyStimulus(32'hA5A5_0000, 0, 0, 0);
        waitDone(2000);
        checkClean("ideal");
        checkTraffic("ideal");
        check32("pinAw1", capAw1, 32'h0000_0040);
        check32("pinW17", capW17, 32'hA5A5_0044);
        check32("pinW31", capW31, 32'hA5A5_007C);

        $display("[TB] bit flip at 0x44");
        applyStimulus(32'hA5A5_0000, 0, 1, 0);
        waitDone(2000);
        check32("flip_done", {31'd0, done}, 32'd1);
        check32("flip_pass", {31'd0, pass}, 32'd0);
        check32("flip_errCount", {16'd0, err_count}, 32'd1);
        check32("flip_firstErr", first_err_addr, 32'h0000_0044);

        $display("[TB] random stalls");
        applyStimulus(32'hA5A5_0000, 1, 0, 0);
        waitDone(4000);
        checkClean("stall");
        checkTraffic("stall");

        $display("[TB] SLVERR on first write burst");
        applyStimulus(32'h3C3C_1234, 0, 0, 1);
        waitDone(2000);
        check32("bresp_done", {31'd0, done}, 32'd1);
        check32("bresp_pass", {31'd0, pass}, 32'd0);
        check32("bresp_errNonZero", 32'(err_count != 16'd0), 32'd1);
        check32("bresp_rCount", 32'(nR), 32'(WORDS_P));

        $display("[TB] reset during write beat 5");
        applyStimulus(32'h5555_AAAA, 0, 0, 0);
        waitBeats(5);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check32("midRstValids", {27'd0, axi4_awvalid, axi4_wvalid, axi4_bready, axi4_arvalid, axi4_rready}, 32'd0);
        check32("midRstStatus", {29'd0, busy, done, pass}, 32'd0);
        check32("midRstErr", {16'd0, err_count}, 32'd0);
        check32("midRstFirst", first_err_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h1234_5678, 0, 0, 0);
        waitDone(2000);
        checkClean("postRst");
        checkTraffic("postRst");

        $display("[TB] start pulsed while busy");
        applyStimulus(32'h0F0F_F0F0, 0, 0, 0);
        waitBeats(3);
        start = 1'b1; seed = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; seed = 32'h0;
        waitDone(2000);
        checkClean("busyStart");
        checkTraffic("busyStart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 300000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
